// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Produces stall and flush controls, execute-stage forwarding selects,
// a data-memory wait tracker with timeout, and saturating perf counters.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_RUN  | normal operation, no outstanding memory wait
// ST_WAIT | memory request stalled, counting consecutive wait cycles
// ST_ERROR| memory wait timed out; pipeline frozen until reset
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
  input  logic                      memReadE_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
  input  logic                      regWriteM_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
  input  logic                      regWriteW_i,
  input  logic                      branchTakenE_i,
  input  logic                      memReqM_i,
  input  logic                      memReadyM_i,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      stallE_o,
  output logic                      stallM_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic                      flushW_o,
  output logic [1:0]                forwardAE_o,
  output logic [1:0]                forwardBE_o,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERROR} state_t;

  state_t               r_state;
  logic [WCW-1:0]       r_wait_cnt;
  logic                 r_err;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_mem_wait;
  logic w_lw_stall;
  logic w_frozen;
  logic w_branch_flush;

  assign w_mem_wait = memReqM_i && !memReadyM_i;
  assign w_lw_stall = memReadE_i && (rdE_i != '0) &&
                      ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
  // Memory wait and error both freeze every stage; branch/load-use wait behind them.
  assign w_frozen       = (r_state == ST_ERROR) || w_mem_wait;
  assign w_branch_flush = rst_ni && !w_frozen && branchTakenE_i;

  // Operand forwarding: M-stage result is newer than W-stage, so it wins.
  always_comb begin
    forwardAE_o = 2'b00;
    forwardBE_o = 2'b00;
    if (regWriteM_i && (rdM_i != '0) && (rdM_i == rs1E_i))      forwardAE_o = 2'b10;
    else if (regWriteW_i && (rdW_i != '0) && (rdW_i == rs1E_i)) forwardAE_o = 2'b01;
    if (regWriteM_i && (rdM_i != '0) && (rdM_i == rs2E_i))      forwardBE_o = 2'b10;
    else if (regWriteW_i && (rdW_i != '0) && (rdW_i == rs2E_i)) forwardBE_o = 2'b01;
  end

  // Stall/flush priority: reset, frozen, branch, load-use.
  always_comb begin
    stallF_o = 1'b0;
    stallD_o = 1'b0;
    stallE_o = 1'b0;
    stallM_o = 1'b0;
    flushD_o = 1'b0;
    flushE_o = 1'b0;
    flushW_o = 1'b0;
    if (!rst_ni) begin
      flushD_o = 1'b1;
      flushE_o = 1'b1;
      flushW_o = 1'b1;
    end else if (w_frozen) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      stallE_o = 1'b1;
      stallM_o = 1'b1;
      flushW_o = 1'b1;
    end else if (branchTakenE_i) begin
      flushD_o = 1'b1;
      flushE_o = 1'b1;
    end else if (w_lw_stall) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      flushE_o = 1'b1;
    end
  end

  // Memory-wait FSM; the wait counter holds the number of wait cycles already seen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_wait) begin
            if (TIMEOUT <= 1) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= WCW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (!w_mem_wait) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        ST_ERROR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF_o && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_branch_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign err_o       = r_err;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit (small TIMEOUT and counter width).
module tb_hazard_unit;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk_i;
  logic          rst_ni;
  logic [RW-1:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
  logic          memReadE_i, regWriteM_i, regWriteW_i, branchTakenE_i;
  logic          memReqM_i, memReadyM_i;
  logic          stallF_o, stallD_o, stallE_o, stallM_o;
  logic          flushD_o, flushE_o, flushW_o;
  logic [1:0]    forwardAE_o, forwardBE_o;
  logic          err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_unit #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
    .rdE_i(rdE_i), .memReadE_i(memReadE_i),
    .rdM_i(rdM_i), .regWriteM_i(regWriteM_i),
    .rdW_i(rdW_i), .regWriteW_i(regWriteW_i),
    .branchTakenE_i(branchTakenE_i),
    .memReqM_i(memReqM_i), .memReadyM_i(memReadyM_i),
    .stallF_o(stallF_o), .stallD_o(stallD_o), .stallE_o(stallE_o), .stallM_o(stallM_o),
    .flushD_o(flushD_o), .flushE_o(flushE_o), .flushW_o(flushW_o),
    .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    rs1D_i = '0; rs2D_i = '0; rs1E_i = '0; rs2E_i = '0;
    rdE_i = '0; rdM_i = '0; rdW_i = '0;
    memReadE_i = 0; regWriteM_i = 0; regWriteW_i = 0; branchTakenE_i = 0;
    memReqM_i = 0; memReadyM_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 0;
    #12;
    n_tests++;
    if ({stallF_o, stallD_o, stallE_o, stallM_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_stalls: got %b want 0000", {stallF_o, stallD_o, stallE_o, stallM_o});
    end
    n_tests++;
    if ({flushD_o, flushE_o, flushW_o} !== 3'b111) begin
      n_fail++; $display("FAIL reset_flushes: got %b want 111", {flushD_o, flushE_o, flushW_o});
    end
    n_tests++;
    if (err_o !== 1'b0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL reset_regs: err=%b stall_cnt=%0d flush_cnt=%0d want 0/0/0", err_o, stall_cnt_o, flush_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    #1;
    n_tests++;
    if ({stallF_o, flushD_o, flushE_o, flushW_o} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_outputs: got %b want 0000", {stallF_o, flushD_o, flushE_o, flushW_o});
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk_i);
    rs1E_i = 5; rdM_i = 5; regWriteM_i = 1; rdW_i = 5; regWriteW_i = 1;
    #1;
    n_tests++;
    if (forwardAE_o !== 2'b10) begin n_fail++; $display("FAIL fwdA_mem: got %b want 10", forwardAE_o); end
    regWriteM_i = 0; #1;
    n_tests++;
    if (forwardAE_o !== 2'b01) begin n_fail++; $display("FAIL fwdA_wb: got %b want 01", forwardAE_o); end
    rs1E_i = 0; #1;
    n_tests++;
    if (forwardAE_o !== 2'b00) begin n_fail++; $display("FAIL fwdA_x0: got %b want 00", forwardAE_o); end
    rs2E_i = 9; rdM_i = 9; regWriteM_i = 1; rdW_i = 9; #1;
    n_tests++;
    if (forwardBE_o !== 2'b10) begin n_fail++; $display("FAIL fwdB_mem: got %b want 10", forwardBE_o); end
    rdM_i = 3; #1;
    n_tests++;
    if (forwardBE_o !== 2'b01) begin n_fail++; $display("FAIL fwdB_wb: got %b want 01", forwardBE_o); end
    regWriteW_i = 0; #1;
    n_tests++;
    if (forwardBE_o !== 2'b00 || stallF_o !== 1'b0) begin
      n_fail++; $display("FAIL fwdB_none: fwdB=%b stallF=%b want 00/0", forwardBE_o, stallF_o);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    memReadE_i = 1; rdE_i = 7; rs2D_i = 7; rs1D_i = 2;
    #1;
    n_tests++;
    if ({stallF_o, stallD_o, flushE_o, flushD_o, stallE_o} !== 5'b11100) begin
      n_fail++; $display("FAIL lw_stall: got FDfEfDsE=%b want 11100", {stallF_o, stallD_o, flushE_o, flushD_o, stallE_o});
    end
    @(negedge clk_i);
    memReadE_i = 0;
    #1;
    n_tests++;
    if (stall_cnt_o !== 4'd1 || stallF_o !== 1'b0) begin
      n_fail++; $display("FAIL lw_count: stall_cnt=%0d stallF=%b want 1/0", stall_cnt_o, stallF_o);
    end
    memReadE_i = 1; rdE_i = 0; rs1D_i = 0; rs2D_i = 0;
    #1;
    n_tests++;
    if (stallF_o !== 1'b0 || flushE_o !== 1'b0) begin
      n_fail++; $display("FAIL lw_x0: stallF=%b flushE=%b want 0/0", stallF_o, flushE_o);
    end
    @(negedge clk_i);
    n_tests++;
    if (stall_cnt_o !== 4'd1) begin n_fail++; $display("FAIL lw_x0_count: got %0d want 1", stall_cnt_o); end
    clear_inputs();
  endtask

  task automatic test_branch_vs_lw();
    do_reset();
    memReadE_i = 1; rdE_i = 4; rs1D_i = 4; branchTakenE_i = 1;
    #1;
    n_tests++;
    if ({flushD_o, flushE_o, stallF_o, stallD_o} !== 4'b1100) begin
      n_fail++; $display("FAIL branch_prio: got fDfEsFsD=%b want 1100", {flushD_o, flushE_o, stallF_o, stallD_o});
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    n_tests++;
    if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL branch_count: flush_cnt=%0d stall_cnt=%0d want 1/0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    memReqM_i = 1; memReadyM_i = 0; branchTakenE_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({stallF_o, stallD_o, stallE_o, stallM_o, flushW_o, flushD_o, flushE_o} !== 7'b1111100) begin
        n_fail++; $display("FAIL wait_cycle%0d: got %b want 1111100", i, {stallF_o, stallD_o, stallE_o, stallM_o, flushW_o, flushD_o, flushE_o});
      end
      @(negedge clk_i);
    end
    memReadyM_i = 1;
    #1;
    n_tests++;
    if ({stallF_o, stallM_o, flushW_o, flushD_o, flushE_o} !== 5'b00011) begin
      n_fail++; $display("FAIL wait_release: got sFsMfWfDfE=%b want 00011", {stallF_o, stallM_o, flushW_o, flushD_o, flushE_o});
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    n_tests++;
    if (stall_cnt_o !== 4'd3 || flush_cnt_o !== 4'd1 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL wait_counts: stall=%0d flush=%0d err=%b want 3/1/0", stall_cnt_o, flush_cnt_o, err_o);
    end
    // A fresh 3-cycle wait must not time out if the wait counter was cleared.
    memReqM_i = 1;
    repeat (3) @(negedge clk_i);
    memReadyM_i = 1;
    @(negedge clk_i);
    clear_inputs();
    #1;
    n_tests++;
    if (err_o !== 1'b0 || stall_cnt_o !== 4'd6) begin
      n_fail++; $display("FAIL wait_rerun: err=%b stall=%0d want 0/6", err_o, stall_cnt_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    memReqM_i = 1; memReadyM_i = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      n_tests++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_early%0d: err=%b want 0", i, err_o); end
      @(negedge clk_i);
    end
    n_tests++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err: err=%b want 1", err_o); end
    memReadyM_i = 1; branchTakenE_i = 1;
    #1;
    n_tests++;
    if ({stallF_o, stallD_o, stallE_o, stallM_o, flushW_o, flushD_o, flushE_o} !== 7'b1111100) begin
      n_fail++; $display("FAIL error_hold: got %b want 1111100", {stallF_o, stallD_o, stallE_o, stallM_o, flushW_o, flushD_o, flushE_o});
    end
    @(negedge clk_i);
    #2;
    n_tests++;
    if (err_o !== 1'b1 || stall_cnt_o !== 4'd5 || flush_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL error_state: err=%b stall=%0d flush=%0d want 1/5/0", err_o, stall_cnt_o, flush_cnt_o);
    end
    rst_ni = 0;
    #1;
    n_tests++;
    if (err_o !== 1'b0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || stallF_o !== 1'b0 || flushD_o !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: err=%b stall=%0d flush=%0d stallF=%b flushD=%b want 0/0/0/0/1",
                         err_o, stall_cnt_o, flush_cnt_o, stallF_o, flushD_o);
    end
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1;
    #1;
    n_tests++;
    if (stallF_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: stallF=%b err=%b want 0/0", stallF_o, err_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    memReadE_i = 1; rdE_i = 3; rs1D_i = 3;
    repeat (20) @(negedge clk_i);
    #1;
    n_tests++;
    if (stall_cnt_o !== 4'd15) begin n_fail++; $display("FAIL stall_sat: got %0d want 15", stall_cnt_o); end
    clear_inputs();
    branchTakenE_i = 1;
    repeat (17) @(negedge clk_i);
    #1;
    n_tests++;
    if (flush_cnt_o !== 4'd15 || stall_cnt_o !== 4'd15) begin
      n_fail++; $display("FAIL flush_sat: flush=%0d stall=%0d want 15/15", flush_cnt_o, stall_cnt_o);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lw();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core.
- Generates the stall enables consumed by the fetch and decode pipeline registers (stallF_o drives the fetch flip-flop's active-high stall enable), the flush signals for decode and execute, and the execute-stage forwarding selects.
- Adds a sequential data-memory wait FSM with timeout detection, plus saturating stall and flush performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, performance counter width
- TIMEOUT, 64, maximum consecutive memory-wait cycles before error

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rs1D_i  in  REG_ADDR_WIDTH  decode source 1
- rs2D_i  in  REG_ADDR_WIDTH  decode source 2
- rs1E_i  in  REG_ADDR_WIDTH  execute source 1
- rs2E_i  in  REG_ADDR_WIDTH  execute source 2
- rdE_i  in  REG_ADDR_WIDTH  execute destination
- memReadE_i  in  1  execute instruction is a load
- rdM_i  in  REG_ADDR_WIDTH  memory-stage destination
- regWriteM_i  in  1  memory-stage writes register
- rdW_i  in  REG_ADDR_WIDTH  writeback destination
- regWriteW_i  in  1  writeback writes register
- branchTakenE_i  in  1  execute resolved taken branch/jump
- memReqM_i  in  1  data memory request active in M
- memReadyM_i  in  1  data memory completes request this cycle
- stallF_o  out  1  hold PC register
- stallD_o  out  1  hold F/D register
- stallE_o  out  1  hold D/E register
- stallM_o  out  1  hold E/M register
- flushD_o  out  1  bubble F/D register
- flushE_o  out  1  bubble D/E register
- flushW_o  out  1  bubble M/W register
- forwardAE_o  out  2  rs1E operand select
- forwardBE_o  out  2  rs2E operand select
- err_o  out  1  memory timeout error (sticky)
- stall_cnt_o  out  CNT_WIDTH  cycles with stallF_o high
- flush_cnt_o  out  CNT_WIDTH  branch flush events

Behaviour:
- Reset (rst_ni low, async):
  - state = RUN; wait counter = 0; err_o = 0; both counters = 0.
  - While reset is asserted: all stalls = 0, flushD_o = flushE_o = flushW_o = 1.
- Forwarding (combinational, every state):
  - forwardAE_o = 2'b10 if regWriteM_i and rdM_i == rs1E_i and rdM_i != 0.
  - Otherwise 2'b01 if regWriteW_i and rdW_i == rs1E_i and rdW_i != 0.
  - Otherwise 2'b00. M has priority over W.
  - forwardBE_o: identical rules using rs2E_i.
- memWait = memReqM_i and not memReadyM_i (combinational).
- Load-use: lwStall = memReadE_i and rdE_i != 0 and (rdE_i == rs1D_i or rdE_i == rs2D_i).
- Output priority (highest first):
  1. ERROR state: stallF/D/E/M = 1, flushW = 1, other flushes = 0.
  2. memWait: stallF/D/E/M = 1, flushW = 1, flushD = flushE = 0. Pending branch and load-use are suppressed; they are re-evaluated once stages unfreeze.
  3. branchTakenE_i: flushD = flushE = 1, stallF = stallD = 0. Branch overrides a simultaneous lwStall.
  4. lwStall: stallF = stallD = 1, flushE = 1 for that cycle.
  5. Otherwise all stalls and flushes = 0.
- FSM, registered on posedge clk_i:
  - RUN -> WAIT when memWait; wait counter loads 1.
  - WAIT -> RUN when memReadyM_i or not memReqM_i; counter clears.
  - WAIT stays WAIT while memWait; counter increments.
  - WAIT -> ERROR when memWait holds and counter == TIMEOUT - 1, i.e. on the TIMEOUT-th consecutive wait cycle.
  - ERROR: err_o = 1; absorbing state, left only via reset.
  - Outputs in RUN/WAIT derive from the combinational priority above; the state does not add latency.
- Counters:
  - stall_cnt_o increments on each clock edge where stallF_o = 1.
  - flush_cnt_o increments on each edge where branch flush (priority 3) is active.
  - Both saturate at all-ones and never wrap.
- Register index 0 never causes forwarding or load-use stalls.

Test Plan:
- Forwarding: rs1E=5, rdM=5, regWriteM=1, rdW=5, regWriteW=1 -> forwardAE_o=10. Drop regWriteM -> 01. Set rs1E=0 -> 00.
- Load-use: memReadE=1, rdE=7, rs2D=7 -> stallF=stallD=flushE=1 for one cycle; stall_cnt_o becomes 1. Same with rdE=0 -> no stall.
- Branch vs load-use: lwStall conditions and branchTakenE=1 in the same cycle -> flushD=flushE=1, stallF=0; flush_cnt_o increments by 1.
- Memory wait: memReq=1, memReady=0 for 3 cycles then ready -> stallF/D/E/M and flushW high for exactly 3 cycles; state returns to RUN; stall_cnt_o = 3. branchTakenE held high during the wait -> no flush until release.
- Timeout: TIMEOUT=4, memReq=1, memReady held 0 -> err_o rises after the 4th wait cycle; stalls remain high after memReady asserts. Assert rst_ni=0 mid-error -> err_o=0, counters=0 immediately (async).
- Saturation: CNT_WIDTH=4, 20 stall cycles -> stall_cnt_o = 15 and holds.
